// File: rtl/johnson_pkg.sv
// Shared types and Johnson-pattern helpers for the sequencing controller.
// Helpers take the live width as an argument so one package serves any N up to MaxN.
package johnson_pkg;

  localparam int unsigned MaxN = 16;

  typedef enum logic [0:0] {
    StIdle = 1'b0,
    StRun  = 1'b1
  } state_e;

  // Legal when, walking up from bit 0, the bits change value at most once.
  function automatic logic johnson_legal(input logic [MaxN-1:0] c, input int unsigned n);
    logic msb;
    logic ok;
    msb = c[n-1];
    ok  = 1'b1;
    for (int unsigned i = 1; i < MaxN; i++) begin
      if (i < n) begin
        if (!msb && c[i] && !c[i-1]) ok = 1'b0;
        if (msb && !c[i] && c[i-1]) ok = 1'b0;
      end
    end
    return ok;
  endfunction

  function automatic logic [2*MaxN-1:0] johnson_phase(input logic [MaxN-1:0] c,
                                                      input int unsigned n);
    int unsigned ones;
    int unsigned k;
    logic [2*MaxN-1:0] p;
    ones = 0;
    for (int unsigned i = 0; i < MaxN; i++) begin
      if (i < n && c[i]) ones++;
    end
    k = c[n-1] ? (n + (n - ones)) : ones;
    p = '0;
    if (johnson_legal(c, n)) p[k] = 1'b1;
    return p;
  endfunction

endpackage

// File: rtl/johnson_core.sv
// N-bit Johnson counter register with clear, parallel load and bidirectional step.
module johnson_core
  import johnson_pkg::*;
#(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         dir,
  input  logic         load,
  input  logic [N-1:0] load_val,
  input  logic         clr,
  output logic [N-1:0] count
);

  logic [N-1:0] count_q;
  logic [N-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      count_d = load_val;
    end else if (en) begin
      count_d = dir ? {~count_q[0], count_q[N-1:1]} : {count_q[N-2:0], ~count_q[N-1]};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else       count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/johnson_seq_ctrl.sv
// Run controller for a Johnson counter: stepped runs, phase decode and illegal-pattern recovery.
module johnson_seq_ctrl
  import johnson_pkg::*;
#(
  parameter int unsigned N  = 4,
  parameter int unsigned CW = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stop,
  input  logic           dir,
  input  logic [CW-1:0]  steps,
  input  logic           load,
  input  logic [N-1:0]   load_val,
  output logic [N-1:0]   count,
  output logic [2*N-1:0] phase,
  output logic           busy,
  output logic           done,
  output logic           err
);

  state_e        state_q, state_d;
  logic [CW-1:0] rem_q, rem_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic          err_q, err_d;
  logic          core_en, core_load, core_clr;
  logic          illegal;

  johnson_core #(
    .N(N)
  ) u_core (
    .clk      (clk),
    .reset    (reset),
    .en       (core_en),
    .dir      (dir_q),
    .load     (core_load),
    .load_val (load_val),
    .clr      (core_clr),
    .count    (count)
  );

  assign illegal = !johnson_legal(MaxN'(count), N);

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    dir_d     = dir_q;
    done_d    = 1'b0;
    err_d     = err_q;
    core_en   = 1'b0;
    core_load = 1'b0;
    core_clr  = 1'b0;
    // Recovery overrides everything else, in either state.
    if (illegal) begin
      core_clr = 1'b1;
      err_d    = 1'b1;
      state_d  = StIdle;
      rem_d    = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (load) begin
            core_load = 1'b1;
          end else if (start) begin
            err_d = 1'b0;
            if (steps != '0) begin
              dir_d   = dir;
              rem_d   = steps;
              state_d = StRun;
            end else begin
              done_d = 1'b1;
            end
          end
        end
        StRun: begin
          if (stop) begin
            state_d = StIdle;
            rem_d   = '0;
          end else begin
            core_en = 1'b1;
            rem_d   = rem_q - CW'(1);
            if (rem_q == CW'(1)) begin
              state_d = StIdle;
              done_d  = 1'b1;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      rem_q   <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign phase = (2*N)'(johnson_phase(MaxN'(count), N));
  assign busy  = (state_q == StRun);
  assign done  = done_q;
  assign err   = err_q;

endmodule

// File: tb/tb_johnson_seq_ctrl.sv
// Directed plus randomized bench for johnson_seq_ctrl against a phase-index reference model.
module tb_johnson_seq_ctrl;

  localparam int N  = 4;
  localparam int CW = 8;
  localparam int L  = 2 * N;

  logic           clk = 1'b0;
  logic           reset, start, stop, dir, load;
  logic [CW-1:0]  steps;
  logic [N-1:0]   load_val;
  logic [N-1:0]   count;
  logic [2*N-1:0] phase;
  logic           busy, done, err;

  johnson_seq_ctrl #(
    .N (N),
    .CW(CW)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .start   (start),
    .stop    (stop),
    .dir     (dir),
    .steps   (steps),
    .load    (load),
    .load_val(load_val),
    .count   (count),
    .phase   (phase),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  bit cmp_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: the counter is a position k on a ring of 2N legal values, or a raw illegal value.
  int         m_k;
  bit         m_legal;
  logic [N-1:0] m_raw;
  bit         m_run;
  int         m_rem;
  bit         m_dir, m_done, m_err;
  int         m_tmp;

  function automatic logic [N-1:0] seq_val(input int k);
    int v;
    if (k <= N) v = (1 << k) - 1;
    else        v = ((1 << N) - 1) & ~((1 << (k - N)) - 1);
    return N'(v);
  endfunction

  function automatic int find_k(input logic [N-1:0] v);
    for (int k = 0; k < L; k++) if (seq_val(k) == v) return k;
    return -1;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_k = 0; m_legal = 1; m_run = 0; m_rem = 0; m_done = 0; m_err = 0; m_dir = 0;
    end else if (!m_legal) begin
      m_k = 0; m_legal = 1; m_err = 1; m_run = 0; m_rem = 0; m_done = 0;
    end else if (!m_run) begin
      m_done = 0;
      if (load) begin
        m_tmp = find_k(load_val);
        if (m_tmp < 0) begin
          m_legal = 0;
          m_raw   = load_val;
        end else begin
          m_k = m_tmp;
        end
      end else if (start) begin
        m_err = 0;
        if (steps != 0) begin
          m_run = 1; m_rem = int'(steps); m_dir = dir;
        end else begin
          m_done = 1;
        end
      end
    end else begin
      m_done = 0;
      if (stop) begin
        m_run = 0;
      end else begin
        m_k = m_dir ? (m_k + L - 1) % L : (m_k + 1) % L;
        m_rem--;
        if (m_rem == 0) begin
          m_run = 0; m_done = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      check("model_count", 32'(count), 32'(m_legal ? seq_val(m_k) : m_raw));
      check("model_phase", 32'(phase), m_legal ? (32'd1 << m_k) : 32'd0);
      check("model_busy", 32'(busy), 32'(m_run));
      check("model_done", 32'(done), 32'(m_done));
      check("model_err", 32'(err), 32'(m_err));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    start = 0; stop = 0; load = 0; dir = 0; steps = '0; load_val = '0;
  endtask

  initial begin
    reset = 1;
    idle_inputs();
    tick();
    reset = 0;
    cmp_en = 1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_phase", 32'(phase), 32'h01);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_err", 32'(err), 32'h0);

    // Forward run of 3 from 0000.
    start = 1; dir = 0; steps = 8'd3; tick(); start = 0;
    check("fwd_busy_e0", 32'(busy), 32'h1);
    tick(); check("fwd_e1", 32'(count), 32'h1);
    tick(); check("fwd_e2", 32'(count), 32'h3);
    tick();
    check("fwd_e3", 32'(count), 32'h7);
    check("fwd_phase", 32'(phase), 32'h08);
    check("fwd_done", 32'(done), 32'h1);
    check("fwd_busy_end", 32'(busy), 32'h0);

    // Reverse run of 2 from 0000, then wrap 1000 -> 0000.
    load = 1; load_val = 4'b0000; tick(); load = 0;
    start = 1; dir = 1; steps = 8'd2; tick(); start = 0;
    tick(); check("rev_e1", 32'(count), 32'h8);
    tick();
    check("rev_e2", 32'(count), 32'hC);
    check("rev_phase", 32'(phase), 32'h40);
    check("rev_done", 32'(done), 32'h1);
    load = 1; load_val = 4'b1000; tick(); load = 0;
    start = 1; dir = 0; steps = 8'd1; tick(); start = 0;
    tick();
    check("wrap_count", 32'(count), 32'h0);
    check("wrap_done", 32'(done), 32'h1);

    // Stop during the 4th busy cycle.
    start = 1; dir = 0; steps = 8'd10; tick(); start = 0;
    tick(); tick(); tick();
    stop = 1; tick(); stop = 0;
    check("stop_count", 32'(count), 32'h7);
    check("stop_busy", 32'(busy), 32'h0);
    check("stop_done", 32'(done), 32'h0);

    // Zero-step start.
    start = 1; steps = 8'd0; tick(); start = 0;
    check("zero_done", 32'(done), 32'h1);
    check("zero_count", 32'(count), 32'h7);
    check("zero_busy", 32'(busy), 32'h0);
    tick(); check("zero_done_drop", 32'(done), 32'h0);

    // Illegal load and recovery.
    load = 1; load_val = 4'b0101; tick(); load = 0;
    check("ill_loaded", 32'(count), 32'h5);
    check("ill_phase0", 32'(phase), 32'h00);
    tick();
    check("ill_count", 32'(count), 32'h0);
    check("ill_err", 32'(err), 32'h1);
    check("ill_phase", 32'(phase), 32'h01);
    start = 1; dir = 0; steps = 8'd1; tick(); start = 0;
    check("ill_err_clr", 32'(err), 32'h0);
    tick(); check("ill_after", 32'(count), 32'h1);

    // Load and start together: load wins.
    load = 1; load_val = 4'b0011; start = 1; steps = 8'd5; tick(); load = 0; start = 0;
    check("coll_count", 32'(count), 32'h3);
    check("coll_busy", 32'(busy), 32'h0);

    // Start during RUN is ignored.
    start = 1; dir = 0; steps = 8'd2; tick();
    steps = 8'd7; tick(); start = 0;
    check("rerun_busy", 32'(busy), 32'h1);
    tick();
    check("rerun_count", 32'(count), 32'hF);
    check("rerun_done", 32'(done), 32'h1);
    check("rerun_busy_end", 32'(busy), 32'h0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++) begin
      reset    = ($urandom_range(0, 99) < 2);
      load     = ($urandom_range(0, 7) == 0);
      load_val = N'($urandom);
      start    = ($urandom_range(0, 4) == 0);
      stop     = ($urandom_range(0, 11) == 0);
      dir      = 1'($urandom);
      steps    = ($urandom_range(0, 15) == 0) ? CW'($urandom) : CW'($urandom_range(0, 12));
      tick();
    end

    reset = 0;
    idle_inputs();
    tick();
    tick();
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
